// File: rtl/eau_seq_if.sv
// rtl/eau_seq_if.sv - requester/exchange-unit signal bundle for eau_seq
interface eau_seq_if;

  // Requester command side
  logic req;
  logic op;
  logic byte_vld;

  // Sequencer status back to the requester
  logic busy;
  logic ack;
  logic byte_rdy;
  logic hi_phase;

  // Exchange-unit strobes; do_o carries the "do" strobe because do is a keyword
  logic ai;
  logic ao;
  logic di;
  logic do_o;
  logic hs;
  logic ls;

  // Requester / control-logic view
  modport master (
    output req, op, byte_vld,
    input  busy, ack, byte_rdy, hi_phase,
    input  ai, ao, di, do_o, hs, ls
  );

  // Sequencer view
  modport slave (
    input  req, op, byte_vld,
    output busy, ack, byte_rdy, hi_phase,
    output ai, ao, di, do_o, hs, ls
  );

endinterface

// File: rtl/eau_seq.sv
// rtl/eau_seq.sv - byte/address exchange unit sequencer (optional feature macro: EAU_SEQ_HOLD_EN)
module eau_seq #(
  parameter int unsigned DRIVE_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  eau_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_D_LO  = 3'd1;
  localparam logic [2:0] S_D_HI  = 3'd2;
  localparam logic [2:0] S_A_DRV = 3'd3;
  localparam logic [2:0] S_A_CAP = 3'd4;
  localparam logic [2:0] S_A_LO  = 3'd5;
  localparam logic [2:0] S_A_HI  = 3'd6;

  // Every drive phase runs from this value down to zero, so it lasts DRIVE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(DRIVE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       ack_q,   ack_d;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == 4'd0);

  // Next-state, drive-counter and completion-pulse logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The ack cycle is also an IDLE cycle, so a held req chains commands.
        if (bus.req) begin
          state_d = bus.op ? S_A_CAP : S_D_LO;
        end
      end
      S_D_LO: begin
        // Dropping req aborts; the low half already loaded stays in the unit.
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (bus.byte_vld) begin
          state_d = S_D_HI;
        end
      end
      S_D_HI: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (bus.byte_vld) begin
          state_d = S_A_DRV;
          cnt_d   = CNT_LOAD;
        end
      end
      S_A_DRV: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
`ifdef EAU_SEQ_HOLD_EN
          // Keep the address on the bus for as long as the requester asks.
          if (!bus.req) begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
          end
`else
          state_d = S_IDLE;
          ack_d   = 1'b1;
`endif
        end
      end
      S_A_CAP: begin
        // Single capture cycle loads both address halves at once.
        state_d = S_A_LO;
        cnt_d   = CNT_LOAD;
      end
      S_A_LO: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_A_HI;
          cnt_d   = CNT_LOAD;
        end
      end
      S_A_HI: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and ack registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Strobe decode from the current state; ls/hs follow byte_vld while loading bytes
  always_comb begin
    bus.byte_rdy = 1'b0;
    bus.hi_phase = 1'b0;
    bus.ai       = 1'b0;
    bus.ao       = 1'b0;
    bus.di       = 1'b0;
    bus.do_o     = 1'b0;
    bus.hs       = 1'b0;
    bus.ls       = 1'b0;
    case (state_q)
      S_D_LO: begin
        bus.di = 1'b1;
        bus.ls = bus.byte_vld;
      end
      S_D_HI: begin
        bus.di       = 1'b1;
        bus.hs       = bus.byte_vld;
        bus.hi_phase = 1'b1;
      end
      S_A_DRV: begin
        bus.ao = 1'b1;
      end
      S_A_CAP: begin
        bus.ai = 1'b1;
        bus.hs = 1'b1;
        bus.ls = 1'b1;
      end
      S_A_LO: begin
        // ai stays up so each ls strobe reloads the same, stable address.
        bus.ai       = 1'b1;
        bus.ls       = 1'b1;
        bus.do_o     = 1'b1;
        bus.byte_rdy = 1'b1;
      end
      S_A_HI: begin
        bus.ai       = 1'b1;
        bus.hs       = 1'b1;
        bus.do_o     = 1'b1;
        bus.byte_rdy = 1'b1;
        bus.hi_phase = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.ack  = ack_q;

endmodule

// File: tb/tb_eau_seq.sv
// tb/tb_eau_seq.sv - directed self-checking bench for eau_seq (honours EAU_SEQ_HOLD_EN)
module tb_eau_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  eau_seq_if if1 ();
  eau_seq_if if2 ();

  eau_seq #(.DRIVE_CYCLES(1)) u_seq1 (.clk(clk), .rst(rst), .bus(if1));
  eau_seq #(.DRIVE_CYCLES(2)) u_seq2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side buses and a behavioural exchange unit per instance
  logic [7:0]  dbus1, dbus2;
  logic [15:0] abus1, abus2;
  logic [7:0]  xlo1, xhi1, xlo2, xhi2;
  logic [7:0]  dout2;

  always @(posedge clk) begin
    if (if1.ls) xlo1 <= if1.di ? dbus1 : (if1.ai ? abus1[7:0]  : 8'h00);
    if (if1.hs) xhi1 <= if1.di ? dbus1 : (if1.ai ? abus1[15:8] : 8'h00);
    if (if2.ls) xlo2 <= if2.di ? dbus2 : (if2.ai ? abus2[7:0]  : 8'h00);
    if (if2.hs) xhi2 <= if2.di ? dbus2 : (if2.ai ? abus2[15:8] : 8'h00);
  end

  assign dout2 = if2.do_o ? (if2.hi_phase ? xhi2 : xlo2) : 8'h00;

  // Output vector: busy ack byte_rdy hi_phase ai ao di do hs ls
  logic [9:0] v1, v2;
  assign v1 = {if1.busy, if1.ack, if1.byte_rdy, if1.hi_phase, if1.ai, if1.ao, if1.di, if1.do_o, if1.hs, if1.ls};
  assign v2 = {if2.busy, if2.ack, if2.byte_rdy, if2.hi_phase, if2.ai, if2.ao, if2.di, if2.do_o, if2.hs, if2.ls};

  task automatic chkv(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic r, input logic o, input logic bv, input logic [7:0] d);
    if1.req = r; if1.op = o; if1.byte_vld = bv; dbus1 = d;
  endtask

  task automatic set2(input logic r, input logic o, input logic bv, input logic [7:0] d);
    if2.req = r; if2.op = o; if2.byte_vld = bv; dbus2 = d;
  endtask

  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_ACK   = 10'b0100000000;
  localparam logic [9:0] V_DLO   = 10'b1000001001;
  localparam logic [9:0] V_DHI   = 10'b1001001010;
  localparam logic [9:0] V_DRV   = 10'b1000010000;
  localparam logic [9:0] V_CAP   = 10'b1000100011;
  localparam logic [9:0] V_ALO   = 10'b1010100101;
  localparam logic [9:0] V_AHI   = 10'b1011100110;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    abus1  = 16'h0000;
    abus2  = 16'hBEEF;
    set1(1'b0, 1'b0, 1'b0, 8'h00);
    set2(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state
    tick(); tick();
    chkv("reset_u1", v1, V_IDLE);
    chkv("reset_u2", v2, V_IDLE);
    rst = 1'b1;

    // D2A, DRIVE_CYCLES=1: 0x34 then 0x12, ack 4 cycles after acceptance
    set1(1'b1, 1'b0, 1'b0, 8'h00); #1 chkv("d2a_idle", v1, V_IDLE);
    tick(); set1(1'b1, 1'b0, 1'b1, 8'h34); #1 chkv("d2a_lo", v1, V_DLO);
    tick(); set1(1'b1, 1'b0, 1'b1, 8'h12); #1 chkv("d2a_hi", v1, V_DHI);
    tick(); set1(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("d2a_drv", v1, V_DRV);
    chk16("d2a_addr", {xhi1, xlo1}, 16'h1234);
    tick(); chkv("d2a_ack", v1, V_ACK);
    tick(); chkv("d2a_done", v1, V_IDLE);

    // Abort in D_HI after low byte 0x55: no ack, high half untouched
    set1(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); set1(1'b1, 1'b0, 1'b1, 8'h55); #1 chkv("abort_lo", v1, V_DLO);
    tick(); set1(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("abort_hi", v1, 10'b1001001000);
    tick(); chkv("abort_idle", v1, V_IDLE);
    tick(); chkv("abort_no_ack", v1, V_IDLE);
    chk16("abort_reg", {xhi1, xlo1}, 16'h1255);

    // A2D, DRIVE_CYCLES=2, address 0xBEEF: EF x2, BE x2, ack at cycle 6
    set2(1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chkv("a2d_cap", v2, V_CAP);
    tick(); chkv("a2d_lo0", v2, V_ALO); chk16("a2d_lo0_data", {8'h00, dout2}, 16'h00EF);
    tick(); chkv("a2d_lo1", v2, V_ALO); chk16("a2d_lo1_data", {8'h00, dout2}, 16'h00EF);
    tick(); chkv("a2d_hi0", v2, V_AHI); chk16("a2d_hi0_data", {8'h00, dout2}, 16'h00BE);
    tick(); chkv("a2d_hi1", v2, V_AHI); chk16("a2d_hi1_data", {8'h00, dout2}, 16'h00BE);
    tick(); set2(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("a2d_ack", v2, V_ACK);
    tick(); chkv("a2d_done", v2, V_IDLE);

    // Back-to-back: A2D then D2A accepted in the ack cycle
    set2(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) tick();
    chkv("b2b_hi1", v2, V_AHI);
    tick(); set2(1'b1, 1'b0, 1'b0, 8'h00); #1 chkv("b2b_ack", v2, V_ACK);
    tick(); set2(1'b1, 1'b0, 1'b1, 8'hCD); #1 chkv("b2b_d_lo", v2, V_DLO);
    tick(); set2(1'b1, 1'b0, 1'b1, 8'hAB); #1 chkv("b2b_d_hi", v2, V_DHI);
    tick(); set2(1'b1, 1'b0, 1'b0, 8'h00); #1 chkv("b2b_drv0", v2, V_DRV);
    chk16("b2b_addr", {xhi2, xlo2}, 16'hABCD);
    tick(); set2(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("b2b_drv1", v2, V_DRV);
    tick(); chkv("b2b_ack2", v2, V_ACK);
    tick(); chkv("b2b_done", v2, V_IDLE);

    // Hold: req kept high past the A_DRV count
    set1(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); set1(1'b1, 1'b0, 1'b1, 8'h78);
    tick(); set1(1'b1, 1'b0, 1'b1, 8'h56);
    tick(); set1(1'b1, 1'b0, 1'b0, 8'h00); #1 chkv("hold_drv", v1, V_DRV);
    chk16("hold_addr", {xhi1, xlo1}, 16'h5678);
`ifdef EAU_SEQ_HOLD_EN
    for (int i = 0; i < 5; i++) begin
      tick(); chkv("hold_ext", v1, V_DRV);
    end
    tick(); set1(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("hold_last", v1, V_DRV);
    tick(); chkv("hold_ack", v1, V_ACK);
`else
    tick(); chkv("hold_ack", v1, V_ACK);
    tick(); set1(1'b0, 1'b0, 1'b0, 8'h00); #1 chkv("hold_reaccept", v1, 10'b1000001000);
    tick(); chkv("hold_abort", v1, V_IDLE);
`endif
    tick(); chkv("hold_done", v1, V_IDLE);

    // Reset mid-A_LO, then a normal D2A on the same instance
    set2(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    tick(); chkv("rst_mid_lo", v2, V_ALO);
    set2(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    tick(); chkv("rst_forced", v2, V_IDLE);
    rst = 1'b1;
    tick(); chkv("rst_after", v2, V_IDLE);
    set2(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); set2(1'b1, 1'b0, 1'b1, 8'h11); #1 chkv("rst_d2a_lo", v2, V_DLO);
    tick(); set2(1'b1, 1'b0, 1'b1, 8'h22); #1 chkv("rst_d2a_hi", v2, V_DHI);
    tick(); set2(1'b1, 1'b0, 1'b0, 8'h00); #1 chkv("rst_d2a_drv", v2, V_DRV);
    chk16("rst_d2a_addr", {xhi2, xlo2}, 16'h2211);
    tick(); set2(1'b0, 1'b0, 1'b0, 8'h00);
    tick(); chkv("rst_d2a_ack", v2, V_ACK);
    tick(); chkv("rst_d2a_done", v2, V_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
